seg_glyph_render: RTL and testbench
===================================

Name: seg_glyph_render

Overview:
- Sequential, parametrised successor to the single-letter overlay renderers.
- Draws one 7-segment-style glyph (digits 0-9, P, L, A, Y, dash, blank) at a programmable screen position. Stroke and segment sizes are configurable, and the glyph can optionally blink.
- Position, code and blink settings are shadow-latched at frame start, so the glyph never tears mid-frame.
- Sits between the VGA pixel counters and the colour mux; score and status text is built from multiple instances.

Parameters:
- X_W, 10, width of every coordinate bus.
- STROKE, 5, segment thickness in pixels.
- SEG_H, 16, inner length of horizontal segments.
- SEG_V, 15, inner length of vertical segments.
- BLINK_FRAMES, 30, frames per blink half-period (minimum 1).
- Derived: W = 2*STROKE+SEG_H (26); H = 3*STROKE+2*SEG_V (45).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- start_x  in  X_W  glyph left edge (live value).
- start_y  in  X_W  glyph top edge (live value).
- code  in  4  glyph select (live value).
- blink_en  in  1  blink enable (live value).
- pixel_valid  in  1  x/y are in the active area.
- x  in  X_W  current pixel column.
- y  in  X_W  current pixel row.
- display  out  1  glyph pixel on (2-cycle latency).
- display_valid  out  1  pixel_valid delayed 2 cycles.

Behaviour:
- Reset (async, rst_n=0) sets:
  - Outputs: display=0, display_valid=0.
  - All pipeline registers cleared.
  - Shadow: sx=0, sy=0, code=15 (blank), blink_en=0.
  - Blink: blink_cnt=0, phase=1 (visible).
  - Release is synchronous to clk.
  - Reset mid-frame drops the in-flight pixels; there is no output until a new frame_start (the blank shadow renders nothing).
- Shadow latch:
  - On a clk edge with frame_start=1, latch start_x, start_y, code and blink_en into the shadow registers.
  - Rendering uses only shadow values; live inputs changing mid-frame have no effect.
- Blink:
  - On each frame_start, blink_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and phase toggles.
  - visible = ~blink_en_sh | phase.
  - The counter runs regardless of blink_en.
- Stage 1 (registered):
  - dx = x - sx and dy = y - sy, computed at X_W+1 bits.
  - in_box requires x ≥ sx, y ≥ sy, dx < W and dy < H. The comparison uses the extended width, so there is no wrap-around: a glyph overlapping the right or bottom screen edge is clipped, never folded to column/row 0.
  - Segment region hits, all conditions also requiring in_box:
    - a: STROKE ≤ dx < STROKE+SEG_H, and dy < STROKE.
    - g: same dx range, and STROKE+SEG_V ≤ dy < 2*STROKE+SEG_V.
    - d: same dx range, and dy ≥ H-STROKE.
    - f: dx < STROKE, and STROKE ≤ dy < STROKE+SEG_V.
    - b: dx ≥ STROKE+SEG_H, and STROKE ≤ dy < STROKE+SEG_V.
    - e: dx < STROKE, and 2*STROKE+SEG_V ≤ dy < H-STROKE.
    - c: dx ≥ STROKE+SEG_H, and 2*STROKE+SEG_V ≤ dy < H-STROKE.
    - Outer corners are never lit.
  - Also registered in this stage: the 7-bit segment mask from code_sh, visible, and pixel_valid.
- Stage 2 (registered):
  - display = |(hits & mask) & visible & pv1.
  - display_valid = pv1.
- Segment masks (abcdefg):
  - 0 abcdef
  - 1 bc
  - 2 abdeg
  - 3 abcdg
  - 4 bcfg
  - 5 acdfg
  - 6 acdefg
  - 7 abc
  - 8 all
  - 9 abcdfg
  - 10 P: abefg
  - 11 L: def
  - 12 A: abcefg
  - 13 Y: bcdfg
  - 14 dash: g
  - 15 none
- frame_start coincident with a valid pixel: that pixel's stage 1 uses the pre-latch shadow values. The mask is carried through the pipeline, so the shadow change affects only pixels entering on later cycles.
- pixel_valid=0: display=0 two cycles later, regardless of position.

Test Plan:
- Digit 8, segment a hit. sx=100, sy=50, code=8, pulse frame_start, then drive x=105, y=50, pixel_valid=1 → display=1 and display_valid=1 exactly 2 cycles later. Same code with x=100, y=50 (corner) → display=0.
- Digit 1 columns. code=1, sy=50 (sx=100). x=121..125, y=55 → display=1. x=100..104, y=55 → 0. x=105, y=50 (segment a) → 0.
- Shadow tear-free. Render code=8; mid-frame change code to 15 and sx to 0 → pixels at (105,50) still display=1. After the next frame_start they display 0.
- Blink with BLINK_FRAMES=2, blink_en=1, code=8 → (105,50) lit in frames 0-1, dark in frames 2-3, lit again in frames 4-5. With blink_en=0 → lit in every frame.
- Edge clipping. sx=1015 (X_W=10), code=8 → x=1020, y=sy → display=1. x=2, y=sy → display=0 (no wrap).
- Reset mid-frame. Assert rst_n=0 while display=1 → display and display_valid go to 0 immediately (asynchronously). After release, with no frame_start → display stays 0.

Source files
------------

// File: rtl/seg_glyph_render.sv
// Purpose: overlays one 7-segment glyph (0-9, P, L, A, Y, dash, blank) at a frame-latched position, with optional blink.
// Latency: 2 clk from pixel_valid/x/y to display/display_valid.
// Backpressure: none; one pixel is accepted every clock, and the output follows the pixel stream.
// Ports: clk/rst_n (async active-low); frame_start latches start_x/start_y/code/blink_en into shadow regs;
//        pixel_valid/x/y form the pixel stream in; display/display_valid form the delayed glyph pixel out.
module seg_glyph_render #(
    parameter int X_W          = 10,
    parameter int STROKE       = 5,
    parameter int SEG_H        = 16,
    parameter int SEG_V        = 15,
    parameter int BLINK_FRAMES = 30
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_start,
    input  logic [X_W-1:0] start_x,
    input  logic [X_W-1:0] start_y,
    input  logic [3:0]     code,
    input  logic           blink_en,
    input  logic           pixel_valid,
    input  logic [X_W-1:0] x,
    input  logic [X_W-1:0] y,
    output logic           display,
    output logic           display_valid
);
    localparam int W  = 2*STROKE + SEG_H;
    localparam int H  = 3*STROKE + 2*SEG_V;
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Region boundaries at the extended offset width.
    localparam logic [X_W:0] C_S     = (X_W+1)'(STROKE);
    localparam logic [X_W:0] C_R     = (X_W+1)'(STROKE + SEG_H);
    localparam logic [X_W:0] C_UP_E  = (X_W+1)'(STROKE + SEG_V);
    localparam logic [X_W:0] C_LO_S  = (X_W+1)'(2*STROKE + SEG_V);
    localparam logic [X_W:0] C_D     = (X_W+1)'(H - STROKE);
    localparam logic [X_W:0] C_W     = (X_W+1)'(W);
    localparam logic [X_W:0] C_H     = (X_W+1)'(H);
    localparam logic [CW-1:0] C_BLAST = CW'(BLINK_FRAMES - 1);

    // Shadow registers and blink state.
    logic [X_W-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [3:0]     code_sh_q, code_sh_d;
    logic           blink_en_sh_q, blink_en_sh_d;
    logic [CW-1:0]  blink_cnt_q, blink_cnt_d;
    logic           phase_q, phase_d;

    // Pipeline registers.
    logic [6:0]     hits1_q, hits1_d, mask1_q, mask1_d;
    logic           vis1_q, vis1_d, pv1_q, pv1_d;
    logic           display_q, display_d, display_valid_q, display_valid_d;

    // Stage-1 combinational terms.
    logic [X_W:0]   dx, dy;
    logic           in_box, mid_x, left_x, right_x, upper_y, lower_y;
    logic           seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

    always_comb begin
        sx_d          = sx_q;
        sy_d          = sy_q;
        code_sh_d     = code_sh_q;
        blink_en_sh_d = blink_en_sh_q;
        blink_cnt_d   = blink_cnt_q;
        phase_d       = phase_q;
        if (frame_start) begin
            sx_d          = start_x;
            sy_d          = start_y;
            code_sh_d     = code;
            blink_en_sh_d = blink_en;
            if (blink_cnt_q == C_BLAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        // One extra bit keeps x<sx from wrapping into a small positive offset,
        // so a glyph hanging off the right/bottom edge is clipped, not folded.
        dx      = {1'b0, x} - {1'b0, sx_q};
        dy      = {1'b0, y} - {1'b0, sy_q};
        in_box  = (x >= sx_q) && (y >= sy_q) && (dx < C_W) && (dy < C_H);
        mid_x   = (dx >= C_S) && (dx < C_R);
        left_x  = (dx < C_S);
        right_x = (dx >= C_R);
        upper_y = (dy >= C_S) && (dy < C_UP_E);
        lower_y = (dy >= C_LO_S) && (dy < C_D);
        seg_a   = in_box && mid_x && (dy < C_S);
        seg_g   = in_box && mid_x && (dy >= C_UP_E) && (dy < C_LO_S);
        seg_d   = in_box && mid_x && (dy >= C_D);
        seg_f   = in_box && left_x && upper_y;
        seg_b   = in_box && right_x && upper_y;
        seg_e   = in_box && left_x && lower_y;
        seg_c   = in_box && right_x && lower_y;
        hits1_d = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

        // Mask order abcdefg, bit 6 = a.
        case (code_sh_q)
            4'd0:    mask1_d = 7'b1111110;
            4'd1:    mask1_d = 7'b0110000;
            4'd2:    mask1_d = 7'b1101101;
            4'd3:    mask1_d = 7'b1111001;
            4'd4:    mask1_d = 7'b0110011;
            4'd5:    mask1_d = 7'b1011011;
            4'd6:    mask1_d = 7'b1011111;
            4'd7:    mask1_d = 7'b1110000;
            4'd8:    mask1_d = 7'b1111111;
            4'd9:    mask1_d = 7'b1111011;
            4'd10:   mask1_d = 7'b1100111;
            4'd11:   mask1_d = 7'b0001110;
            4'd12:   mask1_d = 7'b1110111;
            4'd13:   mask1_d = 7'b0111011;
            4'd14:   mask1_d = 7'b0000001;
            default: mask1_d = 7'b0000000;
        endcase

        vis1_d          = ~blink_en_sh_q | phase_q;
        pv1_d           = pixel_valid;
        display_d       = (|(hits1_q & mask1_q)) & vis1_q & pv1_q;
        display_valid_d = pv1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q            <= '0;
            sy_q            <= '0;
            code_sh_q       <= 4'd15;
            blink_en_sh_q   <= 1'b0;
            blink_cnt_q     <= '0;
            phase_q         <= 1'b1;
            hits1_q         <= '0;
            mask1_q         <= '0;
            vis1_q          <= 1'b0;
            pv1_q           <= 1'b0;
            display_q       <= 1'b0;
            display_valid_q <= 1'b0;
        end else begin
            sx_q            <= sx_d;
            sy_q            <= sy_d;
            code_sh_q       <= code_sh_d;
            blink_en_sh_q   <= blink_en_sh_d;
            blink_cnt_q     <= blink_cnt_d;
            phase_q         <= phase_d;
            hits1_q         <= hits1_d;
            mask1_q         <= mask1_d;
            vis1_q          <= vis1_d;
            pv1_q           <= pv1_d;
            display_q       <= display_d;
            display_valid_q <= display_valid_d;
        end
    end

    assign display       = display_q;
    assign display_valid = display_valid_q;
endmodule

// File: tb/tb_seg_glyph_render.sv
// Purpose: directed check of seg_glyph_render (segment regions, masks, shadowing, blink, clipping, reset).
// Latency: expects outputs exactly 2 clk after the pixel is presented.
// Backpressure: n/a; stimulus is a free-running pixel stream.
module tb_seg_glyph_render;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] start_x = '0, start_y = '0, x = '0, y = '0;
    logic [3:0] code = '0;
    logic       blink_en = 1'b0;
    logic       pixel_valid = 1'b0;
    logic       display, display_valid;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seg_glyph_render #(
        .X_W(10), .STROKE(5), .SEG_H(16), .SEG_V(15), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .start_x(start_x), .start_y(start_y), .code(code), .blink_en(blink_en),
        .pixel_valid(pixel_valid), .x(x), .y(y),
        .display(display), .display_valid(display_valid)
    );

    typedef struct {
        int sx; int sy; int cd; int px; int py; bit pv; bit exp_disp;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input int sx, input int sy, input int cd, input int px, input int py,
                       input bit pv, input bit e);
        vec_t v;
        v.sx = sx; v.sy = sy; v.cd = cd; v.px = px; v.py = py; v.pv = pv; v.exp_disp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int sx, input int sy, input int cd, input bit be);
        start_x = 10'(sx); start_y = 10'(sy); code = 4'(cd); blink_en = be;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic pix(input int px, input int py, input bit pv);
        x = 10'(px); y = 10'(py); pixel_valid = pv;
        step();
        pixel_valid = 1'b0;
        step();
    endtask

    initial begin : main
        bit blink_exp[6];
        bit seen;

        // Box is 26x45: a/g/d at dx 5..20, b/c at dx 21..25;
        // a dy 0..4, f/b dy 5..19, g dy 20..24, e/c dy 25..39, d dy 40..44.
        add(100, 50,  8, 105, 50, 1, 1);   // a
        add(100, 50,  8, 100, 50, 1, 0);   // outer corner
        add(100, 50,  1, 121, 55, 1, 1);   // b, first column
        add(100, 50,  1, 125, 55, 1, 1);   // b, last column
        add(100, 50,  1, 126, 55, 1, 0);   // right of box
        add(100, 50,  1, 100, 55, 1, 0);   // f not in "1"
        add(100, 50,  1, 104, 55, 1, 0);
        add(100, 50,  1, 105, 50, 1, 0);   // a not in "1"
        add(100, 50,  8, 110, 72, 1, 1);   // g
        add(100, 50,  0, 110, 72, 1, 0);   // g not in "0"
        add(100, 50,  8, 110, 94, 1, 1);   // d, last row
        add(100, 50,  8, 110, 95, 1, 0);   // below box
        add(100, 50, 14, 110, 70, 1, 1);   // dash
        add(100, 50, 14, 110, 69, 1, 0);   // interior hole
        add(100, 50, 11, 102, 80, 1, 1);   // L: e
        add(100, 50, 11, 123, 60, 1, 0);   // L: no b
        add(100, 50, 15, 105, 50, 1, 0);   // blank
        add(1015, 50, 8, 1020, 50, 1, 1);  // near right edge, still on screen
        add(1015, 50, 8,    2, 50, 1, 0);  // must not wrap to column 2
        add(100, 50, 12, 110, 94, 1, 0);   // A: no d
        add(100, 50, 12, 110, 50, 1, 1);   // A: a
        add(100, 50,  8, 105, 50, 0, 0);   // invalid pixel
        add(100, 50,  7, 123, 80, 1, 1);   // 7: c
        add(100, 50,  8, 105, 49, 1, 0);   // above box
        add(100, 50,  9, 102, 80, 1, 0);   // 9: no e
        add(100, 50,  6, 102, 80, 1, 1);   // 6: e
        add(100, 50, 13, 110, 94, 1, 1);   // Y: d
        add(100, 50, 13, 102, 80, 1, 0);   // Y: no e

        // Reset state.
        #12;
        chk("reset_display", display, 1'b0);
        chk("reset_display_valid", display_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        // Blank shadow at (0,0): valid pixel, nothing drawn.
        pix(0, 0, 1);
        chk("reset_shadow_blank", display, 1'b0);
        chk("reset_shadow_valid", display_valid, 1'b1);

        foreach (vecs[i]) begin
            load(vecs[i].sx, vecs[i].sy, vecs[i].cd, 1'b0);
            pix(vecs[i].px, vecs[i].py, vecs[i].pv);
            chk($sformatf("vec%0d_display", i), display, vecs[i].exp_disp);
            chk($sformatf("vec%0d_valid", i), display_valid, vecs[i].pv);
        end

        // Exact 2-cycle latency.
        load(100, 50, 8, 1'b0);
        x = 10'd105; y = 10'd50; pixel_valid = 1'b1;
        step();
        pixel_valid = 1'b0;
        chk("lat1_display", display, 1'b0);
        chk("lat1_valid", display_valid, 1'b0);
        step();
        chk("lat2_display", display, 1'b1);
        chk("lat2_valid", display_valid, 1'b1);

        // Live inputs changed mid-frame are ignored until the next frame_start.
        code = 4'd15; start_x = 10'd0;
        pix(105, 50, 1);
        chk("tear_midframe", display, 1'b1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pix(105, 50, 1);
        chk("tear_nextframe", display, 1'b0);

        // frame_start coincident with a pixel: that pixel uses the old shadow.
        load(100, 50, 8, 1'b0);
        code = 4'd15; frame_start = 1'b1;
        x = 10'd105; y = 10'd50; pixel_valid = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        chk("coincident_old", display, 1'b1);
        step();
        pixel_valid = 1'b0;
        chk("coincident_new", display, 1'b0);

        // Reset mid-frame clears outputs asynchronously; nothing shows afterwards.
        load(100, 50, 8, 1'b0);
        x = 10'd105; y = 10'd50; pixel_valid = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            seen = display;
        end
        chk("rst_pre_lit", seen, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_display", display, 1'b0);
        chk("rst_async_valid", display_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("rst_after%0d", c), display, 1'b0);
        end
        pixel_valid = 1'b0;
        step();

        // Blink with BLINK_FRAMES=2 from reset (cnt=0, phase=1). Counting the
        // pre-first-pulse frame as frame 0, the frames after pulses 1..6 are
        // frames 1..6: lit, dark, dark, lit, lit, dark.
        blink_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int f = 0; f < 6; f++) begin
            load(100, 50, 8, 1'b1);
            pix(105, 50, 1);
            chk($sformatf("blink_frame%0d", f + 1), display, blink_exp[f]);
        end
        for (int f = 0; f < 4; f++) begin
            load(100, 50, 8, 1'b0);
            pix(105, 50, 1);
            chk($sformatf("noblink_frame%0d", f), display, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
